// File: rtl/arbiter41.sv
// arbiter41: 4-way round-robin arbiter driving a registered 4:1 data selector.
// Ports: iClk, iRst (sync, active-high), iReq[3:0], iC0..iC3[3:0] data in;
//        oGnt[3:0] one-hot grant, {oS1,oS0} select code, oZ[3:0] registered
//        selected data, oValid (oZ carries granted data), oBusy (in GRANT).
module arbiter41 #(
  parameter int unsigned HOLD = 4
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [3:0] iReq,
  input  logic [3:0] iC0,
  input  logic [3:0] iC1,
  input  logic [3:0] iC2,
  input  logic [3:0] iC3,
  output logic [3:0] oGnt,
  output logic       oS1,
  output logic       oS0,
  output logic [3:0] oZ,
  output logic       oValid,
  output logic       oBusy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [3:0] HoldM1 = 4'(HOLD - 1);

  state_e     state_q, state_d;
  logic [1:0] g_q, g_d;
  logic [1:0] p_q, p_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] z_q, z_d;
  logic       valid_q, valid_d;
  logic [3:0] sel_data;
  logic       release_c;

  // First requester after ptr, wrapping so ptr itself is checked last.
  // Scanning from the far end lets the nearest hit overwrite the result.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] ptr,
    input logic [3:0] req
  );
    logic [1:0] idx;
    logic [1:0] pick;
    pick = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    sel_data = iC0;
    unique case (g_q)
      2'd0: sel_data = iC0;
      2'd1: sel_data = iC1;
      2'd2: sel_data = iC2;
      2'd3: sel_data = iC3;
      default: sel_data = iC0;
    endcase
  end

  assign release_c = (cnt_q == 4'd0) || !iReq[g_q];

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (iReq != 4'b0000) begin
          g_d     = rr_pick(p_q, iReq);
          cnt_d   = HoldM1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_c) begin
          // Pointer moves to the releasing owner; re-arbitrate from it
          // in the same edge so there is no idle bubble.
          p_d = g_q;
          if (iReq != 4'b0000) begin
            g_d   = rr_pick(g_q, iReq);
            cnt_d = HoldM1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    z_d     = (state_q == GRANT) ? sel_data : 4'b0000;
    valid_d = (state_q == GRANT);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      g_q     <= 2'd0;
      p_q     <= 2'd3;
      cnt_q   <= 4'd0;
      z_q     <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    oGnt  = 4'b0000;
    oS1   = 1'b0;
    oS0   = 1'b0;
    oBusy = 1'b0;
    if (state_q == GRANT) begin
      oGnt  = 4'b0001 << g_q;
      oS1   = g_q[1];
      oS0   = g_q[0];
      oBusy = 1'b1;
    end
  end

  assign oZ     = z_q;
  assign oValid = valid_q;

endmodule

// File: tb/tb_arbiter41.sv
// tb_arbiter41: directed and random checks of arbiter41
// against a cycle-count round-robin reference model.
module tb_arbiter41;

  localparam int HOLD = 4;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [3:0] iReq;
  logic [3:0] iC0, iC1, iC2, iC3;
  logic [3:0] oGnt;
  logic       oS1, oS0;
  logic [3:0] oZ;
  logic       oValid, oBusy;

  arbiter41 #(.HOLD(HOLD)) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iReq  (iReq),
    .iC0   (iC0),
    .iC1   (iC1),
    .iC2   (iC2),
    .iC3   (iC3),
    .oGnt  (oGnt),
    .oS1   (oS1),
    .oS0   (oS0),
    .oZ    (oZ),
    .oValid(oValid),
    .oBusy (oBusy)
  );

  always #5 iClk = ~iClk;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the selector, how many cycles it has
  // held it, and who was served last.
  bit       m_busy;
  int       m_owner;
  int       m_used;
  int       m_ptr;
  bit [3:0] m_z;
  bit       m_v;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int ptr, input bit [3:0] req);
    for (int k = 1; k <= 4; k++)
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return ptr;
  endfunction

  function automatic bit [3:0] cdata(input int n);
    case (n)
      0: return iC0;
      1: return iC1;
      2: return iC2;
      default: return iC3;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit [3:0] req);
    bit rel;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_used = 0; m_ptr = 3;
      m_z = 0; m_v = 0;
      return;
    end
    m_z = m_busy ? cdata(m_owner) : 4'b0000;
    m_v = m_busy;
    if (!m_busy) begin
      if (req != 0) begin
        m_owner = pick(m_ptr, req);
        m_used = 1;
        m_busy = 1;
      end
    end else begin
      rel = (m_used >= HOLD) || !req[m_owner];
      if (rel) begin
        m_ptr = m_owner;
        if (req != 0) begin
          m_owner = pick(m_ptr, req);
          m_used = 1;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_used++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit [3:0] eg;
    bit [3:0] es;
    eg = m_busy ? 4'(1 << m_owner) : 4'b0000;
    es = m_busy ? 4'(m_owner) : 4'b0000;
    chk({tag, ".gnt"}, oGnt, eg);
    chk({tag, ".sel"}, {2'b00, oS1, oS0}, es);
    chk({tag, ".busy"}, {3'b000, oBusy}, {3'b000, m_busy});
    chk({tag, ".z"}, oZ, m_z);
    chk({tag, ".valid"}, {3'b000, oValid}, {3'b000, m_v});
  endtask

  task automatic cyc(input string tag, input bit rst,
                     input bit [3:0] req);
    iRst = rst;
    iReq = req;
    @(posedge iClk);
    model_edge(rst, req);
    #1;
    check_all(tag);
  endtask

  initial begin
    iRst = 1; iReq = 0;
    iC0 = 0; iC1 = 0; iC2 = 0; iC3 = 0;
    model_edge(1, 0);

    cyc("reset", 1, 4'b1111);
    cyc("reset", 1, 4'b0000);
    chk("reset.gnt0", oGnt, 4'b0000);

    // lone requester 2, back-to-back regrant
    iC2 = 4'b1010;
    for (int i = 0; i < 10; i++) cyc("burst", 0, 4'b0100);
    chk("burst.z", oZ, 4'b1010);
    cyc("idle", 0, 4'b0000);
    cyc("idle", 0, 4'b0000);
    chk("idle.z0", oZ, 4'b0000);

    // rotation with all requesting
    iC0 = 0; iC1 = 1; iC2 = 2; iC3 = 3;
    for (int i = 0; i < 18; i++) cyc("rot", 0, 4'b1111);

    // early drop: 1 granted, drops, 3 takes over
    cyc("rst2", 1, 4'b0000);
    cyc("drop", 0, 4'b0010);
    chk("drop.g1", oGnt, 4'b0010);
    cyc("drop", 0, 4'b0010);
    cyc("drop", 0, 4'b1000);
    chk("drop.g3", oGnt, 4'b1000);
    cyc("drop", 0, 4'b1000);

    // reset in mid-grant then all request
    cyc("rst3", 1, 4'b0000);
    cyc("mid", 0, 4'b0010);
    cyc("mid", 0, 4'b0010);
    cyc("mid", 1, 4'b0010);
    chk("mid.gnt0", oGnt, 4'b0000);
    cyc("mid", 0, 4'b1111);
    chk("mid.first", oGnt, 4'b0001);

    // simultaneous 0 and 3 at release of 3
    cyc("rst4", 1, 4'b0000);
    cyc("sim", 0, 4'b1000);
    for (int i = 0; i < HOLD; i++) cyc("sim", 0, 4'b1001);
    chk("sim.g0", oGnt, 4'b0001);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit [3:0] r;
      iC0 = 4'($urandom); iC1 = 4'($urandom);
      iC2 = 4'($urandom); iC3 = 4'($urandom);
      r = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
      cyc("rand", ($urandom_range(0, 60) == 0), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
